onehot_decoder_stepper: RTL and testbench
=========================================

// Module: onehot_decoder_stepper
// PURPOSE
//  Inverse of the board's priority-encoder demos: holds a binary index and decodes it to a
//  one-hot, active-low LED vector. Index is stepped up/down by debounced push-buttons or by
//  an auto-run timer. Sits directly between board keys and LEDs on the EPM240 board.
// PARAMETERS
//  W            4           number of one-hot outputs (2..16, need not be a power of two)
//  DEBOUNCE_LEN 50_000      consecutive stable cycles required to accept a key change
//  STEP_PERIOD  25_000_000  auto-run step interval in clock cycles (>=2)
// PORTS
//  clk     in   1           system clock
//  rst_n   in   1           synchronous reset, active low
//  key_n   in   3           buttons, active low: [0] step up, [1] step down, [2] toggle run
//  led_n   out  W           one-hot decode of idx, active low
//  idx     out  $clog2(W)   current index, binary
//  run     out  1           1 = auto-run stepping enabled
// BEHAVIOUR
//  Reset: on any clk edge with rst_n=0, all state clears.
//   - Outputs: idx=0, run=0, led_n=~1 (LED0 on).
//   - Internal: sync flops=1 (released), debounced keys=1, debounce and prescaler counters=0.
//   - Reset mid-operation abandons any pending debounce or prescale count.
//  Input conditioning, per key:
//   - 2-flop synchronizer feeds a debounce counter.
//   - Counter increments each cycle the synced value differs from the debounced value.
//   - Counter clears on any cycle where the two match.
//   - At DEBOUNCE_LEN consecutive mismatches, the debounced value takes the synced value
//     and the counter clears.
//   - Press event: 1-cycle pulse when the debounced value goes 1->0. Release makes no event.
//  Latency: key_n first sampled low at edge t and held low means idx (or run) changes at
//   edge t+DEBOUNCE_LEN+2. Glitches shorter than DEBOUNCE_LEN cycles produce no event.
//  Index update, evaluated once per cycle in this priority order:
//   1. up and down press in the same cycle: cancel each other; idx unchanged, tick dropped.
//   2. up press: idx+1. Down press: idx-1.
//   3. otherwise an auto tick: idx+1.
//   - Manual press coincident with a tick: manual wins and the tick is dropped.
//   - Wrap-around: W-1 +1 -> 0; 0 -1 -> W-1. idx never leaves 0..W-1.
//  Run control:
//   - run-key press toggles run on the following edge.
//   - Prescaler clears whenever run is 0 and in the cycle run toggles.
//   - While run=1, prescaler counts 0..STEP_PERIOD-1. The tick is asserted in the cycle
//     count==STEP_PERIOD-1, after which the count wraps to 0.
//   - First auto step lands STEP_PERIOD cycles after run rises.
//   - A run-key press coinciding with a tick toggles run; that tick still applies.
//  Decode: led_n = ~(1 << idx), combinational from the idx register.
//   - Exactly one led_n bit is low at all times, including immediately after reset.
//   - Bits W-1..0 only; no out-of-range state exists.
//  Width rules: idx is $clog2(W) bits. Counters are sized $clog2(DEBOUNCE_LEN+1) and
//   $clog2(STEP_PERIOD). Wrap compare is against W-1 explicitly, not natural overflow.
// TESTING (bench uses W=5, DEBOUNCE_LEN=4, STEP_PERIOD=8)
//  1 Reset then idle 50 cycles -> idx=0, led_n=5'b11110, run=0 throughout.
//  2 key_n[0] low from edge t, held 20 cycles -> idx=1 exactly at edge t+6, led_n=5'b11101;
//    release, repeat 4x -> idx sequence 2,3,4,0 (wrap).
//  3 From idx=0, press key_n[1] -> idx=4, led_n=5'b01111.
//    Then 3-cycle low glitch on key_n[1] -> no change.
//  4 Press key_n[0] and key_n[1] on the same edge, held -> idx unchanged, no event on release.
//  5 Press key_n[2] -> run=1; idx then increments every 8 cycles, first step 8 cycles after
//    run rises. Up press aligned to a tick -> single +1.
//    Second key_n[2] press -> run=0, stepping stops.
//  6 rst_n low for 1 cycle mid debounce, with run=1 and idx=3
//    -> next edge idx=0, run=0, led_n=5'b11110; the held key needs a full DEBOUNCE_LEN again.

Source files
------------

// File: rtl/onehot_decoder_stepper.sv
// -----------------------------------------------------------------------------
// onehot_decoder_stepper
//   Holds a binary index and decodes it to a one-hot, active-low LED vector.
//   The index steps up or down on debounced push-button presses. It can also
//   step up on a free-running auto-run timer, which a third button toggles.
//
// Parameters
//   W            number of one-hot outputs (2..16, need not be a power of two)
//   DEBOUNCE_LEN consecutive stable cycles required to accept a key change
//   STEP_PERIOD  auto-run step interval in clock cycles (>= 2)
//
// Ports
//   clk    in   1           system clock
//   rst_n  in   1           synchronous reset, active low
//   key_n  in   3           buttons, active low: [0] up, [1] down, [2] toggle run
//   led_n  out  W           one-hot decode of idx, active low
//   idx    out  $clog2(W)   current index, binary
//   run    out  1           1 = auto-run stepping enabled
//
// Key handshake: there is no valid/ready pair. A press is a single-cycle
// pulse that the index/run logic consumes unconditionally in the cycle it is
// high. Releasing a key never produces a pulse.
// -----------------------------------------------------------------------------
module onehot_decoder_stepper #(
   parameter int W            = 4,
   parameter int DEBOUNCE_LEN = 50_000,
   parameter int STEP_PERIOD  = 25_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [2:0]           key_n,
   output logic [W-1:0]         led_n,
   output logic [$clog2(W)-1:0] idx,
   output logic                 run
);

   localparam int IDX_W = $clog2(W);
   localparam int DB_W  = $clog2(DEBOUNCE_LEN + 1);
   localparam int PS_W  = $clog2(STEP_PERIOD);

   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(W - 1);
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_LEN - 1);
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(STEP_PERIOD - 1);
   localparam logic [W-1:0]     ONE_W   = W'(1);

   logic [2:0]       sync1;
   logic [2:0]       sync2;
   logic [2:0]       key_db;
   logic [2:0]       press;
   logic [PS_W-1:0]  pre_cnt;
   logic             tick;
   logic [IDX_W-1:0] idx_next;
   logic [IDX_W-1:0] idx_inc;
   logic [IDX_W-1:0] idx_dec;

   // Two-flop synchronizer. Reset to 1 so that a released key is assumed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 3'b111;
         sync2 <= 3'b111;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
      end
   end

   // Per-key debounce. The counter holds the length of the current run of
   // cycles in which the synchronized level differs from the accepted level.
   // When the run reaches DEBOUNCE_LEN, the new level is accepted. If that
   // new level is low, a press pulse is emitted in the following cycle.
   for (genvar k = 0; k < 3; k++) begin : g_key
      logic [DB_W-1:0] cnt;
      logic            db;
      logic            prs;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt <= '0;
            db  <= 1'b1;
            prs <= 1'b0;
         end else begin
            prs <= 1'b0;
            if (sync2[k] != db) begin
               if (cnt == DB_LAST) begin
                  db  <= sync2[k];
                  cnt <= '0;
                  prs <= ~sync2[k];
               end else begin
                  cnt <= cnt + DB_W'(1);
               end
            end else begin
               cnt <= '0;
            end
         end
      end

      assign key_db[k] = db;
      assign press[k]  = prs;
   end

   // The auto-run tick is high in the last cycle of each STEP_PERIOD window.
   assign tick = run && (pre_cnt == PS_LAST);

   // Run toggle and prescaler. The prescaler restarts whenever run is off,
   // and also in the cycle where run toggles. As a result, the first auto
   // step lands exactly STEP_PERIOD cycles after run rises.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run     <= 1'b0;
         pre_cnt <= '0;
      end else begin
         if (press[2]) begin
            run <= ~run;
         end
         if (!run || press[2] || tick) begin
            pre_cnt <= '0;
         end else begin
            pre_cnt <= pre_cnt + PS_W'(1);
         end
      end
   end

   // Wrap is compared against W-1 explicitly, because W need not be a
   // power of two.
   assign idx_inc = (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
   assign idx_dec = (idx == '0) ? IDX_MAX : idx - IDX_W'(1);

   // Manual presses outrank the tick. Simultaneous up and down presses
   // cancel each other, and the tick in that cycle is dropped as well.
   always_comb begin
      idx_next = idx;
      if (press[0] && press[1]) begin
         idx_next = idx;
      end else if (press[0]) begin
         idx_next = idx_inc;
      end else if (press[1]) begin
         idx_next = idx_dec;
      end else if (tick) begin
         idx_next = idx_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx <= '0;
      end else begin
         idx <= idx_next;
      end
   end

   assign led_n = ~(ONE_W << idx);

endmodule

// File: tb/tb_onehot_decoder_stepper.sv
module tb_onehot_decoder_stepper;

  localparam int W  = 5;
  localparam int DL = 4;
  localparam int SP = 8;

  logic         clk;
  logic         rst_n;
  logic [2:0]   key_n;
  logic [W-1:0] led_n;
  logic [2:0]   idx;
  logic         run;

  int total;
  int bad;

  onehot_decoder_stepper #(.W(W), .DEBOUNCE_LEN(DL), .STEP_PERIOD(SP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .led_n (led_n),
    .idx   (idx),
    .run   (run)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model. Each key keeps the raw level seen two clocks earlier and
  // the length of the current run of cycles that disagree with the accepted
  // level. A press is an accepted 1->0 transition; it is acted on one cycle
  // later. The index is kept as an integer modulo W. The auto-run position is
  // an integer phase within the STEP_PERIOD window.
  // ---------------------------------------------------------------------------
  int m_idx;
  bit m_run;
  int m_phase;
  bit m_raw1 [3];
  bit m_raw2 [3];
  bit m_acc  [3];
  int m_len  [3];
  bit m_pend [3];

  always @(posedge clk) begin
    bit tick_now;
    if (!rst_n) begin
      m_idx = 0; m_run = 0; m_phase = 0;
      for (int k = 0; k < 3; k++) begin
        m_raw1[k] = 1; m_raw2[k] = 1; m_acc[k] = 1; m_len[k] = 0; m_pend[k] = 0;
      end
    end else begin
      tick_now = m_run && (m_phase == SP - 1);
      if (m_pend[0] && m_pend[1]) m_idx = m_idx;
      else if (m_pend[0])         m_idx = (m_idx + 1) % W;
      else if (m_pend[1])         m_idx = (m_idx + W - 1) % W;
      else if (tick_now)          m_idx = (m_idx + 1) % W;
      m_phase = (!m_run || m_pend[2]) ? 0 : (m_phase + 1) % SP;
      if (m_pend[2]) m_run = !m_run;
      for (int k = 0; k < 3; k++) begin
        m_pend[k] = 0;
        if (m_raw2[k] != m_acc[k]) begin
          m_len[k]++;
          if (m_len[k] == DL) begin
            m_acc[k]  = m_raw2[k];
            m_len[k]  = 0;
            m_pend[k] = (m_raw2[k] == 0);
          end
        end else begin
          m_len[k] = 0;
        end
        m_raw2[k] = m_raw1[k];
        m_raw1[k] = key_n[k];
      end
    end
  end

  function automatic logic [W-1:0] led_of(int i);
    logic [W-1:0] v;
    v = '1;
    for (int b = 0; b < W; b++) if (b == i) v[b] = 1'b0;
    return v;
  endfunction

  // scoreboard
  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of the DUT against the model, one step after each edge.
  always @(posedge clk) begin
    #1;
    chk("model_idx", int'(idx), m_idx);
    chk("model_run", int'(run), int'(m_run));
    chk("model_led", int'(led_n), int'(led_of(m_idx)));
  end

  // driver tasks
  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_keys(logic [2:0] v);
    @(negedge clk);
    key_n = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    key_n = 3'b111;
    edges(1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_state(string name, int e_idx, int e_run);
    chk({name, "_idx"}, int'(idx), e_idx);
    chk({name, "_run"}, int'(run), e_run);
    chk({name, "_led"}, int'(led_n), int'(led_of(e_idx)));
  endtask

  typedef struct {
    logic [2:0] keys;
    int         hold;
    int         e_idx;
    logic       e_run;
  } vec_t;

  vec_t vecs [14];

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    key_n = 3'b111;
    edges(2);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 50; i++) begin
      edges(1);
      chk_state("idle", 0, 0);
    end
    chk("idle_led_const", int'(led_n), 5'b11110);

    // table-driven vectors, starting from reset
    vecs[0]  = '{3'b110, 10, 1, 1'b0};
    vecs[1]  = '{3'b111, 10, 1, 1'b0};
    vecs[2]  = '{3'b101, 10, 0, 1'b0};
    vecs[3]  = '{3'b111, 10, 0, 1'b0};
    vecs[4]  = '{3'b101, 10, 4, 1'b0};
    vecs[5]  = '{3'b111, 10, 4, 1'b0};
    vecs[6]  = '{3'b110,  2, 4, 1'b0};
    vecs[7]  = '{3'b111, 10, 4, 1'b0};
    vecs[8]  = '{3'b100, 10, 4, 1'b0};
    vecs[9]  = '{3'b111, 10, 4, 1'b0};
    vecs[10] = '{3'b011, 10, 4, 1'b1};
    vecs[11] = '{3'b111, 10, 0, 1'b1};
    vecs[12] = '{3'b011, 10, 1, 1'b0};
    vecs[13] = '{3'b111, 10, 1, 1'b0};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive_keys(vecs[i].keys);
      edges(vecs[i].hold);
      chk_state($sformatf("vec%0d", i), vecs[i].e_idx, int'(vecs[i].e_run));
    end

    // 2: exact latency, then wrap-around
    do_reset();
    drive_keys(3'b110);
    edges(6);
    chk("lat_before", int'(idx), 0);
    edges(1);
    chk_state("lat_at", 1, 0);
    chk("lat_led_const", int'(led_n), 5'b11101);
    edges(13);
    drive_keys(3'b111);
    edges(20);
    for (int i = 0; i < 4; i++) begin
      drive_keys(3'b110);
      edges(20);
      drive_keys(3'b111);
      edges(20);
      chk_state($sformatf("wrap%0d", i), (2 + i) % W, 0);
    end

    // 3: down wraps to W-1; short glitch is ignored
    drive_keys(3'b101);
    edges(10);
    chk_state("down_wrap", 4, 0);
    chk("down_led_const", int'(led_n), 5'b01111);
    drive_keys(3'b111);
    edges(20);
    drive_keys(3'b101);
    edges(3);
    drive_keys(3'b111);
    edges(20);
    chk_state("glitch", 4, 0);

    // 4: up and down together cancel, release gives nothing
    do_reset();
    drive_keys(3'b100);
    edges(20);
    chk_state("both_held", 0, 0);
    drive_keys(3'b111);
    edges(20);
    chk_state("both_rel", 0, 0);

    // 5: auto-run timing, manual press aligned to a tick, stop
    do_reset();
    drive_keys(3'b011);           // first low sample at edge t
    edges(6);                     // t+5
    chk("run_before", int'(run), 0);
    edges(1);                     // t+6, run rises
    chk("run_rise", int'(run), 1);
    drive_keys(3'b111);
    edges(7);                     // t+13
    chk("step_before", int'(idx), 0);
    edges(1);                     // t+14
    chk("step_first", int'(idx), 1);
    edges(9);                     // t+23
    chk("step_second", int'(idx), 2);
    drive_keys(3'b110);           // up sampled from t+24, lands at t+30 = tick
    edges(6);                     // t+29
    chk("align_before", int'(idx), 2);
    edges(1);                     // t+30
    chk("align_single", int'(idx), 3);
    edges(1);                     // t+31
    chk("align_after", int'(idx), 3);
    drive_keys(3'b111);
    edges(6);                     // t+37
    chk("tick_after_align_pre", int'(idx), 3);
    edges(1);                     // t+38
    chk("tick_after_align", int'(idx), 4);
    drive_keys(3'b011);           // sampled from t+39, run falls at t+45
    edges(6);                     // t+44
    chk("stop_before", int'(run), 1);
    edges(1);                     // t+45
    chk_state("stop_at", 4, 0);
    drive_keys(3'b111);
    edges(30);
    chk_state("stopped", 4, 0);

    // 6: reset mid debounce while running
    do_reset();
    drive_keys(3'b011);
    edges(7);                     // t+6
    drive_keys(3'b111);
    edges(24);                    // t+30
    chk_state("pre_rst", 3, 1);
    drive_keys(3'b110);
    edges(2);                     // t+32
    @(negedge clk);
    rst_n = 1'b0;
    edges(1);                     // t+33
    chk_state("mid_rst", 0, 0);
    chk("mid_rst_led_const", int'(led_n), 5'b11110);
    @(negedge clk);
    rst_n = 1'b1;
    edges(6);                     // t+39
    chk("rst_redeb_before", int'(idx), 0);
    edges(1);                     // t+40
    chk_state("rst_redeb_at", 1, 0);
    drive_keys(3'b111);
    edges(20);

    // randomized stimulus, checked against the model every cycle
    for (int i = 0; i < 2500; i++) begin
      logic [2:0] v;
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        edges(1);
        @(negedge clk);
        rst_n = 1'b1;
      end
      v = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
      drive_keys(v);
      edges($urandom_range(1, 12));
    end

    drive_keys(3'b111);
    edges(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
